// File: rtl/bpsk_frame_ctrl.sv
// rtl/bpsk_frame_ctrl.sv - frame sequencer (preamble/sync/header/payload/CRC/gap) feeding the BPSK mapper
// Optional CRC-32 trailer after the payload is built only when BPSK_FRAME_CRC_EN is defined.
module bpsk_frame_ctrl #(
  parameter int unsigned PRE_WORDS   = 2,
  parameter logic [31:0] PRE_PATTERN = 32'hAAAAAAAA,
  parameter logic [31:0] SYNC_WORD   = 32'h1ACFFC1D,
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned GAP_CYCLES  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [15:0]      frame_cnt,
  input  logic             pl_valid,
  input  logic [31:0]      pl_data,
  output logic             pl_ack,
  output logic             map_valid,
  output logic [31:0]      map_data,
  input  logic             map_ack
);

  localparam int unsigned PRE_CW = $clog2(PRE_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SYNC,
    S_HDR,
    S_PAY,
`ifdef BPSK_FRAME_CRC_EN
    S_CRC,
`endif
    S_GAP
  } state_t;

`ifdef BPSK_FRAME_CRC_EN
  localparam state_t S_TAIL = S_CRC;
`else
  localparam state_t S_TAIL = S_GAP;
`endif

  state_t              state;
  state_t              state_nx;
  logic [PRE_CW-1:0]   pre_cnt;
  logic [LEN_W-1:0]    pay_cnt;
  logic [LEN_W-1:0]    len_r;
  logic [31:0]         gap_cnt;
  logic                map_valid_r;
  logic [31:0]         map_data_r;
  logic                xfer;
  logic                pre_last;
  logic                pay_last;
  logic                gap_last;
  logic                aborting;

  assign xfer     = map_valid && map_ack;
  assign pre_last = (pre_cnt == PRE_CW'(PRE_WORDS - 1));
  assign pay_last = (pay_cnt == len_r - 1'b1);
  assign gap_last = (gap_cnt == GAP_CYCLES);
  assign aborting = abort && (state != S_IDLE);

`ifdef BPSK_FRAME_CRC_EN
  logic [31:0] crc_r;
  logic [31:0] crc_nx;

  // MSB-first, non-reflected CRC-32 over one 32-bit word
  function automatic logic [31:0] crc32_word(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? 32'h04C11DB7 : 32'h0);
    end
    return r;
  endfunction

  assign crc_nx = crc32_word(crc_r, pl_data);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // abort takes priority over every other transition out of a busy state
  always_comb begin
    state_nx = state;
    if (aborting) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) state_nx = S_PRE;
        S_PRE:  if (xfer && pre_last) state_nx = S_SYNC;
        S_SYNC: if (xfer) state_nx = S_HDR;
        S_HDR:  if (xfer) state_nx = (len_r != '0) ? S_PAY : S_TAIL;
        S_PAY:  if (xfer && pay_last) state_nx = S_TAIL;
`ifdef BPSK_FRAME_CRC_EN
        S_CRC:  if (xfer) state_nx = S_GAP;
`endif
        S_GAP:  if (gap_last) state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    map_valid = map_valid_r;
    map_data  = map_data_r;
    pl_ack    = 1'b0;
    if (state == S_PAY) begin
      map_valid = pl_valid;
      map_data  = pl_data;
      pl_ack    = map_ack;
    end
    busy = (state != S_IDLE);
    done = (state == S_GAP) && gap_last && !abort;
  end

  // Registered word source for every state except PAY, which is a pass-through
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt     <= '0;
      pay_cnt     <= '0;
      len_r       <= '0;
      gap_cnt     <= '0;
      map_valid_r <= 1'b0;
      map_data_r  <= '0;
      frame_cnt   <= '0;
`ifdef BPSK_FRAME_CRC_EN
      crc_r       <= 32'hFFFFFFFF;
`endif
    end else if (aborting) begin
      map_valid_r <= 1'b0;
      map_data_r  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_r       <= len;
            pre_cnt     <= '0;
            pay_cnt     <= '0;
            gap_cnt     <= '0;
            map_valid_r <= 1'b1;
            map_data_r  <= PRE_PATTERN;
`ifdef BPSK_FRAME_CRC_EN
            crc_r       <= 32'hFFFFFFFF;
`endif
          end
        end
        S_PRE: begin
          if (xfer) begin
            pre_cnt <= pre_cnt + 1'b1;
            if (pre_last) map_data_r <= SYNC_WORD;
          end
        end
        S_SYNC: begin
          if (xfer) map_data_r <= 32'(len_r);
        end
        S_HDR: begin
          if (xfer) begin
            if (len_r != '0) begin
              map_valid_r <= 1'b0;
              map_data_r  <= '0;
            end else begin
`ifdef BPSK_FRAME_CRC_EN
              map_data_r  <= ~crc_r;
`else
              map_valid_r <= 1'b0;
              map_data_r  <= '0;
`endif
            end
          end
        end
        S_PAY: begin
          if (xfer) begin
            pay_cnt <= pay_cnt + 1'b1;
`ifdef BPSK_FRAME_CRC_EN
            crc_r   <= crc_nx;
            if (pay_last) begin
              map_valid_r <= 1'b1;
              map_data_r  <= ~crc_nx;
            end
`endif
          end
        end
`ifdef BPSK_FRAME_CRC_EN
        S_CRC: begin
          if (xfer) begin
            map_valid_r <= 1'b0;
            map_data_r  <= '0;
          end
        end
`endif
        S_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_last) frame_cnt <= frame_cnt + 1'b1;
        end
        default: begin
          map_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bpsk_frame_ctrl.sv
// tb/tb_bpsk_frame_ctrl.sv - self-checking bench for bpsk_frame_ctrl against a word-list frame model
module tb_bpsk_frame_ctrl;

  localparam int          GAP  = 64;
  localparam logic [31:0] PRE  = 32'hAAAAAAAA;
  localparam logic [31:0] SYNC = 32'h1ACFFC1D;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] len;
  logic        abort;
  logic        busy;
  logic        done;
  logic [15:0] frame_cnt;
  logic        pl_valid;
  logic [31:0] pl_data;
  logic        pl_ack;
  logic        map_valid;
  logic [31:0] map_data;
  logic        map_ack;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_frames = 16'h0;
  logic [31:0] pay_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  bpsk_frame_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .busy(busy), .done(done), .frame_cnt(frame_cnt),
    .pl_valid(pl_valid), .pl_data(pl_data), .pl_ack(pl_ack),
    .map_valid(map_valid), .map_data(map_data), .map_ack(map_ack)
  );

  // Byte-serial CRC-32 (poly 04C11DB7, init/xorout FFFFFFFF) over the payload queue
  function automatic logic [31:0] ref_crc();
    logic [31:0] c;
    logic [7:0]  by;
    c = 32'hFFFFFFFF;
    foreach (pay_q[w]) begin
      for (int b = 3; b >= 0; b--) begin
        by = pay_q[w][8*b +: 8];
        c  = c ^ {by, 24'h0};
        repeat (8) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
      end
    end
    return ~c;
  endfunction

  task automatic build_exp(input int n);
    exp_q = {};
    exp_q.push_back(PRE);
    exp_q.push_back(PRE);
    exp_q.push_back(SYNC);
    exp_q.push_back({16'h0, n[15:0]});
    foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
`ifdef BPSK_FRAME_CRC_EN
    exp_q.push_back(ref_crc());
`endif
  endtask

  // ack_mode: 0 always, 1 toggling, 2 random; pv_rand: random payload availability; inject: stray starts
  task automatic run_frame(input int n, input int ack_mode, input bit pv_rand, input bit inject);
    logic [31:0] got_q[$];
    logic [31:0] prev_d;
    bit          pv, prev_v, prev_a, prev_pv, prev_pa, seen_done;
    int          idx, last_k, acks;
    build_exp(n);
    @(negedge clk);
    start = 1'b1; len = n[15:0]; map_ack = 1'b0; pl_valid = 1'b0; abort = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
    idx = 0; pv = 0; prev_v = 0; prev_a = 0; prev_pv = 0; prev_pa = 0; prev_d = '0;
    last_k = 0; seen_done = 0; acks = 0;
    for (int k = 0; k < 3000 && !seen_done; k++) begin
      @(negedge clk);
      start = inject && ($urandom_range(7) == 0);
      len   = 16'($urandom);
      if (prev_pv && prev_pa) begin idx++; pv = 0; end
      if (!pv && idx < n && (!pv_rand || $urandom_range(1) == 1)) pv = 1;
      pl_valid = pv;
      pl_data  = pv ? pay_q[idx] : $urandom;
      case (ack_mode)
        0:       map_ack = 1'b1;
        1:       map_ack = (k % 2 == 0);
        default: map_ack = ($urandom_range(1) == 1);
      endcase
      #1;
      if (k == 0) begin
        checks++;
        if (map_valid !== 1'b1 || map_data !== PRE) begin
          errors++; $display("FAIL start_latency got=%b/%h exp=1/%h", map_valid, map_data, PRE);
        end
      end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_frame k=%0d got=%b exp=1", k, busy); end
      if (prev_v && !prev_a) begin
        checks++;
        if (map_valid !== 1'b1 || map_data !== prev_d) begin
          errors++; $display("FAIL hold k=%0d got=%b/%h exp=1/%h", k, map_valid, map_data, prev_d);
        end
      end
      checks++;
      if (pl_ack === 1'b1 && (map_ack !== 1'b1 || n == 0)) begin
        errors++; $display("FAIL pl_ack k=%0d got=1 exp=0", k);
      end
      if (pl_valid && pl_ack === 1'b1) acks++;
      if (map_valid === 1'b1 && map_ack === 1'b1) begin
        got_q.push_back(map_data);
        last_k = k;
      end
      if (done === 1'b1) begin
        seen_done = 1;
        checks++;
        if (k - last_k != GAP + 1) begin
          errors++; $display("FAIL gap_len got=%0d exp=%0d", k - last_k, GAP + 1);
        end
      end
      prev_v = map_valid; prev_a = map_ack; prev_d = map_data;
      prev_pv = pl_valid; prev_pa = pl_ack;
    end
    checks++;
    if (!seen_done) begin errors++; $display("FAIL done_timeout got=0 exp=1"); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL word_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (acks != n) begin errors++; $display("FAIL pl_acks got=%0d exp=%0d", acks, n); end
    @(negedge clk);
    start = 1'b0; map_ack = 1'b0; pl_valid = 1'b0;
    #1;
    exp_frames++;
    checks++;
    if (frame_cnt !== exp_frames) begin
      errors++; $display("FAIL frame_cnt got=%0d exp=%0d", frame_cnt, exp_frames);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL after_done busy/done got=%b/%b exp=0/0", busy, done);
    end
  endtask

  // Drives a len=3 frame up to the first PAY cycle, with a stray start in PRE
  task automatic run_to_pay(input logic [31:0] d0);
    logic [31:0] e[5];
    e = '{PRE, PRE, SYNC, 32'h3, d0};
    @(negedge clk);
    start = 1'b1; len = 16'd3; map_ack = 1'b1; pl_valid = 1'b0; abort = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start    = (i == 1);
      len      = 16'd7;
      pl_valid = (i == 4);
      pl_data  = d0;
      #1;
      checks++;
      if (map_valid !== 1'b1 || map_data !== e[i]) begin
        errors++; $display("FAIL prefix[%0d] got=%b/%h exp=1/%h", i, map_valid, map_data, e[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0;
    pl_valid = 1'b0; pl_data = '0; map_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({map_valid, map_data, busy, done, pl_ack, frame_cnt} !== '0) begin
      errors++; $display("FAIL reset_state got=%b/%h/%b/%b/%b/%h exp=all0",
                         map_valid, map_data, busy, done, pl_ack, frame_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    pay_q = '{32'h1, 32'h2, 32'h3};
    run_frame(3, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    pay_q = '{32'h1, 32'h2, 32'h3};
    run_frame(3, 1, 1'b0, 1'b0);
  endtask

  task automatic test_len0();
    pay_q = {};
    run_frame(0, 2, 1'b0, 1'b1);
  endtask

  task automatic test_crc();
    pay_q = '{32'hDEADBEEF, 32'h12345678};
    run_frame(2, 2, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int n;
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(8);
      pay_q = {};
      for (int i = 0; i < n; i++) pay_q.push_back($urandom);
      run_frame(n, 2, 1'b1, 1'b1);
    end
  endtask

  task automatic test_abort();
    bit saw_done;
    run_to_pay($urandom);
    @(negedge clk);
    pl_valid = 1'b0; abort = 1'b1; start = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_cycle_busy got=%b exp=1", busy); end
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || map_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_idle busy/valid/done got=%b/%b/%b exp=0/0/0", busy, map_valid, done);
    end
    saw_done = 0;
    repeat (GAP + 10) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL abort_no_done got=1 exp=0"); end
    checks++;
    if (frame_cnt !== exp_frames) begin
      errors++; $display("FAIL abort_frame_cnt got=%0d exp=%0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_back_to_back();
    pay_q = '{32'hCAFEF00D};
    run_frame(1, 0, 1'b0, 1'b0);
    pay_q = '{32'h0BADC0DE, 32'h55AA55AA, 32'hFFFFFFFF};
    run_frame(3, 1, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    run_to_pay(32'h13572468);
    rst = 1'b1;
    #1;
    checks++;
    if ({map_valid, map_data, busy, done, pl_ack, frame_cnt} !== '0) begin
      errors++; $display("FAIL reset_mid_pay got=%b/%h/%b/%b/%b/%h exp=all0",
                         map_valid, map_data, busy, done, pl_ack, frame_cnt);
    end
    @(negedge clk);
    rst = 1'b0; pl_valid = 1'b0; map_ack = 1'b0; start = 1'b0;
    exp_frames = 16'h0;
    pay_q = '{32'h1, 32'h2, 32'h3};
    run_frame(3, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_len0();
    test_crc();
    test_random();
    test_abort();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
